mul_ctrl: RTL and testbench

Sequencer between the execute stage and the shared two-cycle `mul` unit; it implements RISC-V M-extension MUL/MULH/MULHSU/MULHU and MULW. It accepts one multiply request at a time over a valid/ready handshake and decodes the operation into signedness and operand form. It pulses `trig` only while the multiplier is idle, waits for `okay`, then selects and formats the result half. A one-entry product cache lets a MULH*/MUL pair on the same operands complete without a second multiply. A pipeline flush discards the request in flight without corrupting the multiplier.

---
 rtl/mul_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mul_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mul_ctrl
// Purpose  : Sequencer between the execute stage and a shared two-cycle
//            multiplier. Decodes RISC-V MUL/MULH/MULHSU/MULHU/MULW requests,
//            starts the multiplier only while it is idle, formats the
//            selected product half, and keeps a one-entry product cache so
//            a MULH*/MUL pair on the same operands needs only one multiply.
// Ports    : clk, rstn                 - clock, synchronous active-low reset
//            req_valid/req_ready       - request handshake
//            req_op, req_word          - operation, word (*W) form
//            req_rs1, req_rs2          - source operands
//            flush                     - kill the request in flight
//            rsp_valid/rsp_ready       - response handshake
//            rsp_data                  - formatted result
//            mul_trig, mul_flush       - multiplier start pulse / flush
//            mul_signed1/2, mul_src1/2 - multiplier operand signedness/values
//            mul_out, mul_okay         - multiplier product and done strobe
// Revision : 1.0 - initial release
// ============================================================================
module mul_ctrl #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic              req_word,
    input  logic [XLEN-1:0]   req_rs1,
    input  logic [XLEN-1:0]   req_rs2,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              mul_trig,
    output logic              mul_flush,
    output logic              mul_signed1,
    output logic              mul_signed2,
    output logic [XLEN-1:0]   mul_src1,
    output logic [XLEN-1:0]   mul_src2,
    input  logic [2*XLEN-1:0] mul_out,
    input  logic              mul_okay
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [1:0] OP_MUL   = 2'd0;
    localparam logic [1:0] OP_MULHU = 2'd3;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] fmt_result(input logic [2*XLEN-1:0] prod,
                                                   input logic              hi,
                                                   input logic              word);
        if (hi)
            return prod[2*XLEN-1:XLEN];
        else if (word)
            return sext32(prod[31:0]);
        else
            return prod[XLEN-1:0];
    endfunction

    // Registered state
    logic [2:0]        state_q,      state_d;
    logic [XLEN-1:0]   rsp_data_q,   rsp_data_d;
    logic [XLEN-1:0]   src1_q,       src1_d;
    logic [XLEN-1:0]   src2_q,       src2_d;
    logic              sgn1_q,       sgn1_d;
    logic              sgn2_q,       sgn2_d;
    logic              hi_q,         hi_d;
    logic              word_q,       word_d;
    logic              cache_vld_q,  cache_vld_d;
    logic [XLEN-1:0]   cache_src1_q, cache_src1_d;
    logic [XLEN-1:0]   cache_src2_q, cache_src2_d;
    logic              cache_sgn1_q, cache_sgn1_d;
    logic              cache_sgn2_q, cache_sgn2_d;
    logic [2*XLEN-1:0] cache_prod_q, cache_prod_d;

    // Request decode
    logic              dec_word;
    logic              dec_hi;
    logic              dec_s1;
    logic              dec_s2;
    logic [XLEN-1:0]   dec_src1;
    logic [XLEN-1:0]   dec_src2;
    logic              cache_hit;
    logic              cache_fill;

    always_comb begin
        // The word form only exists for MUL on a 64-bit datapath; anything
        // else falls back to the full-width operation.
        dec_word = req_word && (req_op == OP_MUL) && (XLEN == 64);
        dec_src1 = dec_word ? sext32(req_rs1[31:0]) : req_rs1;
        dec_src2 = dec_word ? sext32(req_rs2[31:0]) : req_rs2;
        dec_hi   = (req_op != OP_MUL);
        dec_s1   = (req_op != OP_MULHU);
        dec_s2   = ~req_op[1];
        // The low half of a product is the same for every signedness, so
        // only high-half requests must match the cached signedness.
        cache_hit = cache_vld_q
                 && (dec_src1 == cache_src1_q)
                 && (dec_src2 == cache_src2_q)
                 && (!dec_hi || ((dec_s1 == cache_sgn1_q) && (dec_s2 == cache_sgn2_q)));
    end

    // Every product the multiplier hands back is captured, even when the
    // request that asked for it was flushed.
    assign cache_fill = mul_okay && ((state_q == S_WAIT) || (state_q == S_DRAIN));

    always_comb begin
        state_d      = state_q;
        rsp_data_d   = rsp_data_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        sgn1_d       = sgn1_q;
        sgn2_d       = sgn2_q;
        hi_d         = hi_q;
        word_d       = word_q;
        cache_vld_d  = cache_vld_q;
        cache_src1_d = cache_src1_q;
        cache_src2_d = cache_src2_q;
        cache_sgn1_d = cache_sgn1_q;
        cache_sgn2_d = cache_sgn2_q;
        cache_prod_d = cache_prod_q;

        if (cache_fill) begin
            cache_vld_d  = 1'b1;
            cache_src1_d = src1_q;
            cache_src2_d = src2_q;
            cache_sgn1_d = sgn1_q;
            cache_sgn2_d = sgn2_q;
            cache_prod_d = mul_out;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    if (cache_hit) begin
                        rsp_data_d = fmt_result(cache_prod_q, dec_hi, dec_word);
                        state_d    = S_RESP;
                    end else begin
                        src1_d  = dec_src1;
                        src2_d  = dec_src2;
                        sgn1_d  = dec_s1;
                        sgn2_d  = dec_s2;
                        hi_d    = dec_hi;
                        word_d  = dec_word;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // The trigger has already gone out this cycle; a flush can
                // only turn the wait for the product into a silent drain.
                state_d = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (mul_okay) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        rsp_data_d = fmt_result(mul_out, hi_q, word_q);
                        state_d    = S_RESP;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_RESP: begin
                if (flush || rsp_ready)
                    state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (mul_okay)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            rsp_data_q   <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            sgn1_q       <= 1'b0;
            sgn2_q       <= 1'b0;
            hi_q         <= 1'b0;
            word_q       <= 1'b0;
            cache_vld_q  <= 1'b0;
            cache_src1_q <= '0;
            cache_src2_q <= '0;
            cache_sgn1_q <= 1'b0;
            cache_sgn2_q <= 1'b0;
            cache_prod_q <= '0;
        end else begin
            state_q      <= state_d;
            rsp_data_q   <= rsp_data_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            sgn1_q       <= sgn1_d;
            sgn2_q       <= sgn2_d;
            hi_q         <= hi_d;
            word_q       <= word_d;
            cache_vld_q  <= cache_vld_d;
            cache_src1_q <= cache_src1_d;
            cache_src2_q <= cache_src2_d;
            cache_sgn1_q <= cache_sgn1_d;
            cache_sgn2_q <= cache_sgn2_d;
            cache_prod_q <= cache_prod_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE) && !flush;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_data    = rsp_data_q;
    assign mul_trig    = (state_q == S_ISSUE);
    assign mul_flush   = flush;
    assign mul_signed1 = sgn1_q;
    assign mul_signed2 = sgn2_q;
    assign mul_src1    = src1_q;
    assign mul_src2    = src2_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mul_ctrl
// Purpose  : Self-checking bench for mul_ctrl: a two-cycle multiplier model,
//            an arithmetic reference for every operation, a product-cache
//            predictor, and a scoreboard queue checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_ctrl;

    localparam int XLEN = 64;

    logic              clk = 1'b0;
    logic              rstn;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic              req_word;
    logic [XLEN-1:0]   req_rs1;
    logic [XLEN-1:0]   req_rs2;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic              mul_trig;
    logic              mul_flush;
    logic              mul_signed1;
    logic              mul_signed2;
    logic [XLEN-1:0]   mul_src1;
    logic [XLEN-1:0]   mul_src2;
    logic [2*XLEN-1:0] mul_out;
    logic              mul_okay;

    int checks = 0;
    int errors = 0;
    int trig_cnt = 0;

    logic [63:0] exp_q[$];

    // Predicted cache content (last multiply that completed)
    logic        mc_vld;
    logic [63:0] mc1, mc2;
    logic        mc_s1, mc_s2;

    mul_ctrl #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_word    (req_word),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .flush       (flush),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .mul_trig    (mul_trig),
        .mul_flush   (mul_flush),
        .mul_signed1 (mul_signed1),
        .mul_signed2 (mul_signed2),
        .mul_src1    (mul_src1),
        .mul_src2    (mul_src2),
        .mul_out     (mul_out),
        .mul_okay    (mul_okay)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [127:0] mulx(input logic [63:0] a, input logic [63:0] b,
                                          input logic sa, input logic sb);
        logic [127:0] ea, eb;
        ea = sa ? {{64{a[63]}}, a} : {64'd0, a};
        eb = sb ? {{64{b[63]}}, b} : {64'd0, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        if (w && op == 2'd0) begin
            p = mulx(sx32(a[31:0]), sx32(b[31:0]), 1'b1, 1'b1);
            return sx32(p[31:0]);
        end
        case (op)
            2'd0:    begin p = mulx(a, b, 1'b0, 1'b0); return p[63:0];   end
            2'd1:    begin p = mulx(a, b, 1'b1, 1'b1); return p[127:64]; end
            2'd2:    begin p = mulx(a, b, 1'b1, 1'b0); return p[127:64]; end
            default: begin p = mulx(a, b, 1'b0, 1'b0); return p[127:64]; end
        endcase
    endfunction

    // Two-cycle multiplier: product and okay appear two cycles after trig.
    logic         pipe1;
    logic [127:0] prod1;
    always @(posedge clk) begin
        if (!rstn) begin
            pipe1    <= 1'b0;
            mul_okay <= 1'b0;
            mul_out  <= '0;
        end else begin
            if (mul_trig)
                chk("trig_while_busy", 128'(pipe1 | mul_okay), 128'(0));
            pipe1 <= mul_trig;
            if (mul_trig)
                prod1 <= mulx(mul_src1, mul_src2, mul_signed1, mul_signed2);
            mul_okay <= pipe1;
            mul_out  <= pipe1 ? prod1 : {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Monitor: scoreboard pop on each accepted response, hold checks.
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    always @(negedge clk) begin
        if (rstn) begin
            if (mul_trig) trig_cnt++;
            chk("mul_flush", 128'(mul_flush), 128'(flush));
            if (prev_stall) begin
                chk("rsp_valid_hold", 128'(rsp_valid), 128'(1));
                chk("rsp_data_hold", 128'(rsp_data), 128'(prev_data));
            end
            if (rsp_valid && rsp_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got %0h expected none", rsp_data);
                end else begin
                    chk("rsp_data", 128'(rsp_data), 128'(exp_q.pop_front()));
                end
            end
            prev_stall = rsp_valid && !rsp_ready && !flush;
            prev_data  = rsp_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic set_mc(input logic [63:0] e1, input logic [63:0] e2,
                          input logic s1, input logic s2);
        mc_vld = 1'b1; mc1 = e1; mc2 = e2; mc_s1 = s1; mc_s2 = s2;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic w,
                             input logic [63:0] a, input logic [63:0] b);
        req_valid = 1'b1; req_op = op; req_word = w; req_rs1 = a; req_rs2 = b;
    endtask

    task automatic do_req(input logic [1:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input int hold);
        logic        ew, s1, s2, hi, hit, acc;
        logic [63:0] e1, e2;
        int          lat, t0;
        ew  = w && (op == 2'd0);
        e1  = ew ? sx32(a[31:0]) : a;
        e2  = ew ? sx32(b[31:0]) : b;
        s1  = (op != 2'd3);
        s2  = (op < 2'd2);
        hi  = (op != 2'd0);
        hit = mc_vld && e1 == mc1 && e2 == mc2 && (!hi || (s1 == mc_s1 && s2 == mc_s2));
        @(posedge clk); #1;
        drive_req(op, w, a, b);
        rsp_ready = (hold == 0);
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready;
        end
        chk("accept", 128'(acc), 128'(1));
        t0 = trig_cnt;
        @(posedge clk);
        if (acc) exp_q.push_back(ref_res(op, w, a, b));
        #1;
        req_valid = 1'b0;
        req_rs1 = {$urandom, $urandom};
        req_rs2 = {$urandom, $urandom};
        if (!acc) return;
        @(negedge clk);
        chk("trig_T1", 128'(mul_trig), 128'(!hit));
        if (!hit) begin
            chk("signed", 128'({mul_signed1, mul_signed2}), 128'({s1, s2}));
            chk("src1", 128'(mul_src1), 128'(e1));
            chk("src2", 128'(mul_src2), 128'(e2));
        end
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 128'(lat), hit ? 128'(0) : 128'(3));
        chk("trig_count", 128'(trig_cnt - t0), hit ? 128'(0) : 128'(1));
        for (int i = 0; i < hold; i++) begin
            chk("stall_req_ready", 128'(req_ready), 128'(0));
            @(posedge clk); #1;
            if (i == hold - 1) rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        chk("post_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("post_req_ready", 128'(req_ready), 128'(1));
        if (!hit) set_mc(e1, e2, s1, s2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pool[4];
        logic [1:0]  rop;
        rstn = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_word = 1'b0;
        req_rs1 = '0; req_rs2 = '0; flush = 1'b0; rsp_ready = 1'b1;
        mc_vld = 1'b0; mc1 = '0; mc2 = '0; mc_s1 = 1'b0; mc_s2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(1));
        chk("rst_trig", 128'(mul_trig), 128'(0));
        chk("rst_rsp_data", 128'(rsp_data), 128'(0));
        chk("rst_src", 128'({mul_src1, mul_src2}), 128'(0));

        // Directed operations
        do_req(2'd0, 1'b0, 64'd3, 64'd5, 0);
        do_req(2'd3, 1'b0, '1, '1, 0);
        do_req(2'd0, 1'b0, '1, '1, 0);
        do_req(2'd1, 1'b0, '1, '1, 0);
        do_req(2'd2, 1'b0, '1, 64'd2, 0);
        do_req(2'd1, 1'b0, '1, 64'd2, 0);
        do_req(2'd0, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 0);
        do_req(2'd3, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'h0FED_CBA9_8765_4321, 3);

        // Flush while waiting for the product
        @(posedge clk); #1;
        drive_req(2'd0, 1'b0, 64'd7, 64'd9);
        @(negedge clk);
        chk("fw_accept", 128'(req_ready), 128'(1));
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        chk("fw_ready_T2", 128'(req_ready), 128'(0));
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("fw_ready_T3", 128'(req_ready), 128'(0));
        chk("fw_valid_T3", 128'(rsp_valid), 128'(0));
        @(negedge clk);
        chk("fw_ready_T4", 128'(req_ready), 128'(1));
        chk("fw_valid_T4", 128'(rsp_valid), 128'(0));
        set_mc(64'd7, 64'd9, 1'b1, 1'b1);
        do_req(2'd0, 1'b0, 64'd7, 64'd9, 0);

        // Flush while the response is presented (cache hit, consumer stalled)
        @(posedge clk); #1;
        drive_req(2'd1, 1'b0, 64'd7, 64'd9);
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("fr_accept", 128'(req_ready), 128'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("fr_valid", 128'(rsp_valid), 128'(1));
        @(posedge clk); #1;
        flush = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("fr_dropped", 128'(rsp_valid), 128'(0));
        chk("fr_ready", 128'(req_ready), 128'(1));

        // Flush during ISSUE: trigger still goes out, product drained
        @(posedge clk); #1;
        drive_req(2'd3, 1'b0, 64'd11, 64'd13);
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("fi_trig", 128'(mul_trig), 128'(1));
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("fi_ready_T2", 128'(req_ready), 128'(0));
        @(negedge clk);
        chk("fi_ready_T3", 128'(req_ready), 128'(0));
        @(negedge clk);
        chk("fi_ready_T4", 128'(req_ready), 128'(1));
        chk("fi_valid_T4", 128'(rsp_valid), 128'(0));
        set_mc(64'd11, 64'd13, 1'b0, 1'b0);
        do_req(2'd3, 1'b0, 64'd11, 64'd13, 0);
        do_req(2'd0, 1'b0, 64'd11, 64'd13, 0);

        // Flush together with a new request: nothing accepted
        @(posedge clk); #1;
        drive_req(2'd0, 1'b0, 64'd100, 64'd200);
        flush = 1'b1;
        @(negedge clk);
        chk("fq_ready", 128'(req_ready), 128'(0));
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("fq_no_trig", 128'(mul_trig), 128'(0));
        chk("fq_idle", 128'(req_ready), 128'(1));

        // Reset pulse while waiting for the product
        @(posedge clk); #1;
        drive_req(2'd1, 1'b0, 64'd21, 64'd23);
        @(negedge clk);
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        mc_vld = 1'b0;
        @(negedge clk);
        chk("rw_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rw_req_ready", 128'(req_ready), 128'(1));
        chk("rw_trig", 128'(mul_trig), 128'(0));
        chk("rw_signed", 128'({mul_signed1, mul_signed2}), 128'(0));
        chk("rw_src", 128'({mul_src1, mul_src2}), 128'(0));
        chk("rw_rsp_data", 128'(rsp_data), 128'(0));
        do_req(2'd0, 1'b0, 64'd11, 64'd13, 0);

        // Randomized traffic over a small operand pool to provoke cache hits
        pool[0] = '0;
        pool[1] = '1;
        pool[2] = 64'h8000_0000_0000_0000;
        pool[3] = {$urandom, $urandom};
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) pool[3] = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) pool[2] = {$urandom, $urandom};
            rop = 2'($urandom_range(0, 3));
            do_req(rop, 1'($urandom_range(0, 1)),
                   pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
